// File: rtl/max7219_receiver.sv
// Receive side of the MAX7219 DIN/LOAD/CLK link: shadow register file plus frame strobes.
// Optional Code-B segment decode on the read port: define MAX7219_CODEB_DECODE_EN.
module max7219_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_data,
    input  logic       i_serial_load,
    input  logic       i_serial_clk,
    input  logic [2:0] i_rd_digit,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test,
    output logic       o_frame_stb,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic                   load_dly_q, clk_dly_q;
    // Only frame[11:0] is ever decoded, so the upper nibble is never stored.
    logic [11:0]            shift_q, shift_d;
    logic [4:0]             count_q, count_d;
    logic [7:0]             digit_q [8];
    logic [7:0]             digit_d [8];
    logic [7:0]             decode_q, decode_d;
    logic [3:0]             intensity_q, intensity_d;
    logic [2:0]             scan_q, scan_d;
    logic                   shutdown_n_q, shutdown_n_d;
    logic                   test_q, test_d;
    logic                   stb_q, stb_d;
    logic                   err_q, err_d;

    logic load_rise, load_fall, clk_rise, data_bit;
    logic [3:0] addr;
    logic [7:0] wdata;

    assign data_bit  = data_sync_q[SYNC_STAGES-1];
    assign load_rise = load_sync_q[SYNC_STAGES-1] & ~load_dly_q;
    assign load_fall = ~load_sync_q[SYNC_STAGES-1] & load_dly_q;
    assign clk_rise  = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
    assign addr      = shift_q[11:8];
    assign wdata     = shift_q[7:0];

    always_comb begin
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
        load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], i_serial_load};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
        state_d      = state_q;
        shift_d      = shift_q;
        count_d      = count_q;
        digit_d      = digit_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_d       = scan_q;
        shutdown_n_d = shutdown_n_q;
        test_d       = test_q;
        stb_d        = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_fall) begin
                    state_d = SHIFT;
                    count_d = 5'd0;
                end
            end
            SHIFT: begin
                // A LOAD rise masks any serial clock edge seen in the same cycle.
                if (load_rise) begin
                    if (count_q == 5'd16) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = (count_q != 5'd0);
                    end
                end else if (clk_rise) begin
                    shift_d = {shift_q[10:0], data_bit};
                    if (count_q != 5'd16) begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                stb_d   = 1'b1;
                case (addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_d[addr[2:0] - 3'd1] = wdata;
                    4'h9:    decode_d     = wdata;
                    4'hA:    intensity_d  = wdata[3:0];
                    4'hB:    scan_d       = wdata[2:0];
                    4'hC:    shutdown_n_d = wdata[0];
                    4'hF:    test_d       = wdata[0];
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            data_sync_q  <= '0;
            load_sync_q  <= '0;
            clk_sync_q   <= '0;
            load_dly_q   <= 1'b0;
            clk_dly_q    <= 1'b0;
            shift_q      <= '0;
            count_q      <= '0;
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
            decode_q     <= '0;
            intensity_q  <= '0;
            scan_q       <= '0;
            shutdown_n_q <= 1'b0;
            test_q       <= 1'b0;
            stb_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_sync_q  <= data_sync_d;
            load_sync_q  <= load_sync_d;
            clk_sync_q   <= clk_sync_d;
            load_dly_q   <= load_sync_q[SYNC_STAGES-1];
            clk_dly_q    <= clk_sync_q[SYNC_STAGES-1];
            shift_q      <= shift_d;
            count_q      <= count_d;
            digit_q      <= digit_d;
            decode_q     <= decode_d;
            intensity_q  <= intensity_d;
            scan_q       <= scan_d;
            shutdown_n_q <= shutdown_n_d;
            test_q       <= test_d;
            stb_q        <= stb_d;
            err_q        <= err_d;
        end
    end

`ifdef MAX7219_CODEB_DECODE_EN
    function automatic logic [7:0] codeb(input logic dp, input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h7E;  4'h1: seg = 8'h30;  4'h2: seg = 8'h6D;  4'h3: seg = 8'h79;
            4'h4: seg = 8'h33;  4'h5: seg = 8'h5B;  4'h6: seg = 8'h5F;  4'h7: seg = 8'h70;
            4'h8: seg = 8'h7F;  4'h9: seg = 8'h7B;  4'hA: seg = 8'h01;  4'hB: seg = 8'h4F;
            4'hC: seg = 8'h37;  4'hD: seg = 8'h0E;  4'hE: seg = 8'h67;  default: seg = 8'h00;
        endcase
        return seg | {dp, 7'b0};
    endfunction

    always_comb begin
        o_rd_data = digit_q[i_rd_digit];
        if (decode_q[i_rd_digit]) begin
            o_rd_data = codeb(digit_q[i_rd_digit][7], digit_q[i_rd_digit][3:0]);
        end
    end
`else
    assign o_rd_data = digit_q[i_rd_digit];
`endif

    assign o_decode_mode  = decode_q;
    assign o_intensity    = intensity_q;
    assign o_scan_limit   = scan_q;
    assign o_shutdown_n   = shutdown_n_q;
    assign o_display_test = test_q;
    assign o_frame_stb    = stb_q;
    assign o_frame_err    = err_q;

endmodule
